// File: rtl/sram_mem_controller_if.sv
// Pipeline-side request/response signals and SRAM pins of the memory-stage controller.
// The controller takes the slave modport; the pipeline/SRAM environment takes the master modport.
interface sram_mem_controller_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;

  modport master (
    output rd_en, wr_en, address, write_data, sram_dq_in,
    input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );

  modport slave (
    input  rd_en, wr_en, address, write_data, sram_dq_in,
    output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
endinterface

// File: rtl/sram_mem_controller.sv
// Sequences one 32-bit load/store onto a 16-bit async SRAM as two half-word accesses,
// holding ready low to freeze the pipeline until the access completes.
module sram_mem_controller #(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_mem_controller_if.slave bus
);

  localparam int                 CNT_W      = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_RELOAD = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_store_q, is_store_d;
  logic [16:0]      widx_q, widx_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      read_data_q, read_data_d;

  logic [31:0] offset;
  logic        unused_offset_bits;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic        sram_we_n;

  // Modulo-2^32 offset from the SRAM base; only the word index bits reach the pins.
  assign offset             = bus.address - BASE_ADDR;
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      is_store_q  <= 1'b0;
      widx_q      <= '0;
      wdata_q     <= '0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_store_q  <= is_store_d;
      widx_q      <= widx_d;
      wdata_q     <= wdata_d;
      read_data_q <= read_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_store_d  = is_store_q;
    widx_d      = widx_q;
    wdata_d     = wdata_q;
    read_data_d = read_data_q;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (bus.rd_en || bus.wr_en) begin
          // A simultaneous read+write request is treated as a pure store.
          is_store_d = bus.wr_en;
          widx_d     = offset[18:2];
          wdata_d    = bus.write_data;
          cnt_d      = CNT_RELOAD;
          state_d    = LOW;
        end
      end
      LOW: begin
        sram_addr = {widx_q, 1'b0};
        if (is_store_q) begin
          sram_dq_out = wdata_q[15:0];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
        if (cnt_q == '0) begin
          if (!is_store_q) read_data_d[15:0] = bus.sram_dq_in;
          cnt_d   = CNT_RELOAD;
          state_d = HIGH;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HIGH: begin
        sram_addr = {widx_q, 1'b1};
        if (is_store_q) begin
          sram_dq_out = wdata_q[31:16];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
        if (cnt_q == '0) begin
          if (!is_store_q) read_data_d[31:16] = bus.sram_dq_in;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.ready       = (state_q == DONE) ||
                           ((state_q == IDLE) && !bus.rd_en && !bus.wr_en);
  assign bus.read_data   = read_data_q;
  assign bus.sram_addr   = sram_addr;
  assign bus.sram_dq_out = sram_dq_out;
  assign bus.sram_dq_oe  = sram_dq_oe;
  assign bus.sram_we_n   = sram_we_n;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Scoreboard bench: three controllers (W=2, W=1, W=4) against a shared SRAM model;
// the driver queues expected accesses and a per-cycle monitor checks each completed one.
module tb_sram_mem_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_mem_controller_if if0();
  sram_mem_controller_if if1();
  sram_mem_controller_if if2();

  sram_mem_controller #(.WAIT_CYCLES(2), .BASE_ADDR(32'd1024)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  sram_mem_controller #(.WAIT_CYCLES(1), .BASE_ADDR(32'd1024)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  sram_mem_controller #(.WAIT_CYCLES(4), .BASE_ADDR(32'd1024)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  // Asynchronous SRAM model shared by all three controllers (they run one at a time).
  logic [15:0] mem [0:262143];
  assign if0.sram_dq_in = mem[if0.sram_addr];
  assign if1.sram_dq_in = mem[if1.sram_addr];
  assign if2.sram_dq_in = mem[if2.sram_addr];
  always @(posedge clk) begin
    if (!if0.sram_we_n) mem[if0.sram_addr] <= if0.sram_dq_out;
    if (!if1.sram_we_n) mem[if1.sram_addr] <= if1.sram_dq_out;
    if (!if2.sram_we_n) mem[if2.sram_addr] <= if2.sram_dq_out;
  end

  logic        rdy [3];
  logic [17:0] sa  [3];
  logic [15:0] dq  [3];
  logic        we  [3];
  logic        oe  [3];
  logic [31:0] rdd [3];
  assign rdy[0] = if0.ready;  assign rdy[1] = if1.ready;  assign rdy[2] = if2.ready;
  assign sa[0]  = if0.sram_addr;   assign sa[1]  = if1.sram_addr;   assign sa[2]  = if2.sram_addr;
  assign dq[0]  = if0.sram_dq_out; assign dq[1]  = if1.sram_dq_out; assign dq[2]  = if2.sram_dq_out;
  assign we[0]  = if0.sram_we_n;   assign we[1]  = if1.sram_we_n;   assign we[2]  = if2.sram_we_n;
  assign oe[0]  = if0.sram_dq_oe;  assign oe[1]  = if1.sram_dq_oe;  assign oe[2]  = if2.sram_dq_oe;
  assign rdd[0] = if0.read_data;   assign rdd[1] = if1.read_data;   assign rdd[2] = if2.read_data;

  int wk [3] = '{2, 1, 4};

  typedef struct {
    logic        st;
    logic [17:0] lo;
    logic [15:0] ld;
    logic [15:0] hd;
    logic [31:0] rd;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int n_cmp  = 0;
  int n_fail = 0;
  bit mon_off = 1'b1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input int d, input exp_t e);
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic set_req(input int d, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] wd);
    case (d)
      0: begin if0.rd_en = r; if0.wr_en = w; if0.address = a; if0.write_data = wd; end
      1: begin if1.rd_en = r; if1.wr_en = w; if1.address = a; if1.write_data = wd; end
      default: begin if2.rd_en = r; if2.wr_en = w; if2.address = a; if2.write_data = wd; end
    endcase
  endtask

  // Called at a falling edge with the controller in IDLE; returns at the falling edge
  // of the cycle after DONE, with the request still applied.
  task automatic do_req(input int d, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [17:0] lo, input logic [31:0] rd_exp);
    exp_t e;
    int   n;
    e.st = w;
    e.lo = lo;
    e.ld = w ? wd[15:0]  : 16'h0;
    e.hd = w ? wd[31:16] : 16'h0;
    e.rd = rd_exp;
    push_exp(d, e);
    set_req(d, r, w, a, wd);
    #1;
    check($sformatf("d%0d_ready_low_at_req", d), {31'b0, rdy[d]}, 32'd0);
    n = 0;
    while (rdy[d] !== 1'b1 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 60) begin
      n_cmp++;
      n_fail++;
      $display("FAIL d%0d_done_timeout: got no ready after %0d cycles want ready", d, n);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int d);
    set_req(d, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check($sformatf("d%0d_ready_no_request", d), {31'b0, rdy[d]}, 32'd1);
  endtask

  // Monitor: tracks each access from the first frozen cycle through DONE.
  int          act [3];
  int          fz  [3];
  int          lc  [3];
  int          hc  [3];
  int          wc  [3];
  logic [17:0] loa [3];
  logic [15:0] ldv [3];
  logic [15:0] hdv [3];

  task automatic mon_step(input int k);
    exp_t e;
    int   qn;
    if (mon_off) begin
      act[k] = 0;
    end else if (rdy[k] !== 1'b1) begin
      if (act[k] == 0) begin
        act[k] = 1; fz[k] = 0; lc[k] = 0; hc[k] = 0; wc[k] = 0;
        loa[k] = '0; ldv[k] = '0; hdv[k] = '0;
      end
      if (fz[k] == 1) loa[k] = sa[k];
      if (fz[k] >= 1) begin
        if (sa[k] == loa[k]) begin
          lc[k]++; ldv[k] = dq[k];
        end else if (sa[k] == (loa[k] | 18'd1)) begin
          hc[k]++; hdv[k] = dq[k];
        end
        if (we[k] === 1'b0 && oe[k] === 1'b1) wc[k]++;
      end
      fz[k]++;
    end else if (act[k] != 0) begin
      act[k] = 0;
      case (k)
        0: begin qn = q0.size(); if (qn > 0) e = q0.pop_front(); end
        1: begin qn = q1.size(); if (qn > 0) e = q1.pop_front(); end
        default: begin qn = q2.size(); if (qn > 0) e = q2.pop_front(); end
      endcase
      if (qn == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL d%0d_unexpected_access: got access want none", k);
      end else begin
        check($sformatf("d%0d_frozen_cycles", k), fz[k], 2 * wk[k] + 1);
        check($sformatf("d%0d_lo_addr", k), {14'b0, loa[k]}, {14'b0, e.lo});
        check($sformatf("d%0d_lo_cycles", k), lc[k], wk[k]);
        check($sformatf("d%0d_hi_cycles", k), hc[k], wk[k]);
        check($sformatf("d%0d_we_cycles", k), wc[k], e.st ? 2 * wk[k] : 0);
        check($sformatf("d%0d_lo_dq", k), {16'b0, ldv[k]}, {16'b0, e.ld});
        check($sformatf("d%0d_hi_dq", k), {16'b0, hdv[k]}, {16'b0, e.hd});
        check($sformatf("d%0d_read_data_done", k), rdd[k], e.rd);
        check($sformatf("d%0d_addr_done", k), {14'b0, sa[k]}, 32'd0);
      end
    end
  endtask

  always @(negedge clk) begin
    #2;
    for (int k = 0; k < 3; k++) mon_step(k);
  end

  initial begin
    for (int d = 0; d < 3; d++) set_req(d, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    check("rst_read_data", if0.read_data, 32'h0);
    check("rst_we_n", {31'b0, if0.sram_we_n}, 32'd1);
    check("rst_oe", {31'b0, if0.sram_dq_oe}, 32'd0);
    check("rst_addr", {14'b0, if0.sram_addr}, 32'd0);
    check("rst_ready", {29'b0, if2.ready, if1.ready, if0.ready}, 32'd7);
    rst = 1'b0;
    @(negedge clk);
    mon_off = 1'b0;

    do_req(0, 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 18'd4, 32'h0);
    do_req(0, 1'b1, 1'b0, 32'd1032, 32'h0,        18'd4, 32'hDEADBEEF);
    idle(0);
    @(negedge clk);

    do_req(0, 1'b0, 1'b1, 32'd1024, 32'hA5A55A5A, 18'd0, 32'hDEADBEEF);
    do_req(0, 1'b1, 1'b0, 32'd1024, 32'h0,        18'd0, 32'hA5A55A5A);
    idle(0);
    @(negedge clk);

    do_req(0, 1'b1, 1'b1, 32'd1028, 32'h12345678, 18'd2, 32'hA5A55A5A);
    idle(0);
    check("both_en_mem_lo", {16'b0, mem[2]}, 32'h5678);
    check("both_en_mem_hi", {16'b0, mem[3]}, 32'h1234);
    @(negedge clk);

    // Abandon a store mid-LOW with an asynchronous reset.
    mon_off = 1'b1;
    set_req(0, 1'b0, 1'b1, 32'd1040, 32'h11112222);
    @(negedge clk);
    #1;
    check("midlow_we_n", {31'b0, if0.sram_we_n}, 32'd0);
    rst = 1'b1;
    #1;
    check("midrst_read_data", if0.read_data, 32'h0);
    check("midrst_we_n", {31'b0, if0.sram_we_n}, 32'd1);
    check("midrst_oe", {31'b0, if0.sram_dq_oe}, 32'd0);
    check("midrst_addr", {14'b0, if0.sram_addr}, 32'd0);
    check("midrst_dq_out", {16'b0, if0.sram_dq_out}, 32'd0);
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("midrst_ready", {31'b0, if0.ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mon_off = 1'b0;

    do_req(0, 1'b1, 1'b0, 32'd1032, 32'h0, 18'd4, 32'hDEADBEEF);
    idle(0);
    @(negedge clk);

    do_req(1, 1'b0, 1'b1, 32'd0, 32'h0BADF00D, 18'h3FE00, 32'h0);
    do_req(1, 1'b1, 1'b0, 32'd0, 32'h0,        18'h3FE00, 32'h0BADF00D);
    idle(1);
    @(negedge clk);

    do_req(2, 1'b0, 1'b1, 32'd0, 32'hFEEDC0DE, 18'h3FE00, 32'h0);
    do_req(2, 1'b1, 1'b0, 32'd0, 32'h0,        18'h3FE00, 32'hFEEDC0DE);
    idle(2);

    repeat (3) @(negedge clk);
    #3;
    check("queues_drained", q0.size() + q1.size() + q2.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
